// File: rtl/pulse_gen_pkg.sv
// rtl/pulse_gen_pkg.sv - shared FSM state, enable-byte bit positions and counter width for the pulse generator.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } pg_state_t;

    localparam int EN_BIT        = 0;
    localparam int START_NOW_BIT = 1;
    localparam int INVERT_BIT    = 2;

    localparam int CNT_W_DEF = 32;

endpackage

// File: rtl/pulse_time_match.sv
// rtl/pulse_time_match.sv - start strobe: all seven time-of-day fields equal the user start time on a pps cycle.
module pulse_time_match
    import pulse_gen_pkg::*;
(
    input  logic       i_pps,
    input  logic [7:0] i_year_h,
    input  logic [7:0] i_year_l,
    input  logic [7:0] i_month,
    input  logic [7:0] i_day,
    input  logic [7:0] i_hour,
    input  logic [7:0] i_minutes,
    input  logic [7:0] i_seconds,
    input  logic [7:0] i_usr_year_h,
    input  logic [7:0] i_usr_year_l,
    input  logic [7:0] i_usr_month,
    input  logic [7:0] i_usr_day,
    input  logic [7:0] i_usr_hour,
    input  logic [7:0] i_usr_minutes,
    input  logic [7:0] i_usr_seconds,
    output logic       o_start
);

    logic [55:0] w_now;
    logic [55:0] w_usr;

    assign w_now   = {i_year_h, i_year_l, i_month, i_day, i_hour, i_minutes, i_seconds};
    assign w_usr   = {i_usr_year_h, i_usr_year_l, i_usr_month, i_usr_day,
                      i_usr_hour, i_usr_minutes, i_usr_seconds};
    assign o_start = i_pps && (w_now == w_usr);

endmodule

// File: rtl/pulse_generator_core.sv
// rtl/pulse_generator_core.sv - arm/start/run pulse-train engine with shadowed width/period in microsecond ticks.
// Optional o_pulse_count port and period counter when PULSE_GEN_PULSE_COUNT_EN is defined.
module pulse_generator_core
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick_us,
    input  logic       i_pps,
    input  logic [7:0] i_year_h,
    input  logic [7:0] i_year_l,
    input  logic [7:0] i_month,
    input  logic [7:0] i_day,
    input  logic [7:0] i_hour,
    input  logic [7:0] i_minutes,
    input  logic [7:0] i_seconds,
    input  logic [7:0] i_pulse_enable,
    input  logic [7:0] i_usr_year_h,
    input  logic [7:0] i_usr_year_l,
    input  logic [7:0] i_usr_month,
    input  logic [7:0] i_usr_day,
    input  logic [7:0] i_usr_hour,
    input  logic [7:0] i_usr_minutes,
    input  logic [7:0] i_usr_seconds,
    input  logic [7:0] i_width_high_3,
    input  logic [7:0] i_width_high_2,
    input  logic [7:0] i_width_high_1,
    input  logic [7:0] i_width_high_0,
    input  logic [7:0] i_width_period_3,
    input  logic [7:0] i_width_period_2,
    input  logic [7:0] i_width_period_1,
    input  logic [7:0] i_width_period_0,
    output logic       o_pulse,
    output logic       o_armed,
    output logic       o_running,
    output logic       o_cfg_err
`ifdef PULSE_GEN_PULSE_COUNT_EN
    ,
    output logic [15:0] o_pulse_count
`endif
);

    pg_state_t        r_state;
    logic [CNT_W-1:0] r_phase;
    logic [CNT_W-1:0] r_width_s;
    logic [CNT_W-1:0] r_period_s;
    logic             r_pulse;
    logic             r_armed;
    logic             r_running;
    logic             r_cfg_err;

    logic [31:0]      w_width_bytes;
    logic [31:0]      w_period_bytes;
    logic [CNT_W-1:0] w_width_live;
    logic [CNT_W-1:0] w_period_live;
    logic [CNT_W-1:0] w_phase_inc;
    logic             w_enable;
    logic             w_start_now;
    logic             w_invert;
    logic             w_unused_en;
    logic             w_period_zero;
    logic             w_time_start;
    logic             w_wrap;
    logic             w_start_fire;
    logic             w_wrap_fire;
    logic             w_clr;

    assign w_width_bytes  = {i_width_high_3, i_width_high_2, i_width_high_1, i_width_high_0};
    assign w_period_bytes = {i_width_period_3, i_width_period_2, i_width_period_1, i_width_period_0};
    assign w_width_live   = w_width_bytes[CNT_W-1:0];
    assign w_period_live  = w_period_bytes[CNT_W-1:0];
    assign w_enable       = i_pulse_enable[EN_BIT];
    assign w_start_now    = i_pulse_enable[START_NOW_BIT];
    assign w_invert       = i_pulse_enable[INVERT_BIT];
    assign w_unused_en    = ^i_pulse_enable[7:3];
    assign w_period_zero  = (w_period_live == '0);
    assign w_phase_inc    = r_phase + CNT_W'(1);
    assign w_wrap         = (r_phase == r_period_s - CNT_W'(1));

    pulse_time_match u_time_match (
        .i_pps         (i_pps),
        .i_year_h      (i_year_h),
        .i_year_l      (i_year_l),
        .i_month       (i_month),
        .i_day         (i_day),
        .i_hour        (i_hour),
        .i_minutes     (i_minutes),
        .i_seconds     (i_seconds),
        .i_usr_year_h  (i_usr_year_h),
        .i_usr_year_l  (i_usr_year_l),
        .i_usr_month   (i_usr_month),
        .i_usr_day     (i_usr_day),
        .i_usr_hour    (i_usr_hour),
        .i_usr_minutes (i_usr_minutes),
        .i_usr_seconds (i_usr_seconds),
        .o_start       (w_time_start)
    );

    // Disable and zero-period exits take priority over a start or wrap in the same cycle.
    assign w_start_fire = (r_state == ST_ARMED) && w_enable && !w_period_zero &&
                          ((w_start_now && i_tick_us) || w_time_start);
    assign w_wrap_fire  = (r_state == ST_RUN) && w_enable && i_tick_us && w_wrap;
    assign w_clr        = (r_state == ST_IDLE) || !w_enable ||
                          ((r_state == ST_ARMED) && w_period_zero);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_phase    <= '0;
            r_width_s  <= '0;
            r_period_s <= '0;
            r_pulse    <= 1'b0;
            r_armed    <= 1'b0;
            r_running  <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_cfg_err <= w_period_zero;
            case (r_state)
                ST_IDLE: begin
                    r_phase   <= '0;
                    r_pulse   <= w_invert;
                    r_running <= 1'b0;
                    r_armed   <= 1'b0;
                    if (w_enable && !w_period_zero) begin
                        r_state <= ST_ARMED;
                        r_armed <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    r_pulse <= w_invert;
                    if (!w_enable || w_period_zero) begin
                        r_state <= ST_IDLE;
                        r_armed <= 1'b0;
                    end else if (w_start_fire) begin
                        r_state    <= ST_RUN;
                        r_armed    <= 1'b0;
                        r_running  <= 1'b1;
                        r_phase    <= '0;
                        r_width_s  <= w_width_live;
                        r_period_s <= w_period_live;
                        r_pulse    <= (w_width_live != '0) ^ w_invert;
                    end
                end
                ST_RUN: begin
                    if (!w_enable) begin
                        r_state   <= ST_IDLE;
                        r_running <= 1'b0;
                        r_phase   <= '0;
                        r_pulse   <= w_invert;
                    end else if (w_wrap_fire) begin
                        r_phase <= '0;
                        // A zero live period keeps the previous shadows so the train never stalls.
                        if (!w_period_zero) begin
                            r_width_s  <= w_width_live;
                            r_period_s <= w_period_live;
                            r_pulse    <= (w_width_live != '0) ^ w_invert;
                        end else begin
                            r_pulse    <= (r_width_s != '0) ^ w_invert;
                        end
                    end else if (i_tick_us) begin
                        r_phase <= w_phase_inc;
                        r_pulse <= (w_phase_inc < r_width_s) ^ w_invert;
                    end else begin
                        r_pulse <= (r_phase < r_width_s) ^ w_invert;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_armed   <= 1'b0;
                    r_running <= 1'b0;
                    r_pulse   <= 1'b0;
                end
            endcase
        end
    end

`ifdef PULSE_GEN_PULSE_COUNT_EN
    logic [15:0] r_pulse_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || w_clr) begin
            r_pulse_count <= '0;
        end else if (w_start_fire || w_wrap_fire) begin
            r_pulse_count <= r_pulse_count + 16'd1;
        end
    end

    assign o_pulse_count = r_pulse_count;
`endif

    assign o_pulse   = r_pulse;
    assign o_armed   = r_armed;
    assign o_running = r_running;
    assign o_cfg_err = r_cfg_err;

endmodule

// File: doc/pulse_generator_core.md
# pulse_generator_core

Timing engine downstream of the pulse-generator register bank. It consumes the enable, start date/time, high-width and period bytes, plus the disciplined time-of-day and microsecond tick from the clock-master timebase. It arms on enable, waits for the programmed start second and then emits a periodic pulse train with microsecond resolution on the FPGA output pin.

## Interface
- CNT_W, 32, width of width/period and phase counter (µs units)
- i_clk  in  1  system clock
- i_rst  in  1  reset i_rst, synchronous, active-high; clock i_clk
- i_tick_us  in  1  one-cycle strobe, once per microsecond
- i_pps  in  1  one-cycle strobe on the first cycle the time fields show a new second; always coincides with an i_tick_us
- i_year_h, i_year_l, i_month, i_day, i_hour, i_minutes, i_seconds  in  8 each  current time of day
- i_pulse_enable  in  8  bit0 enable, bit1 start-now (ignore start time), bit2 invert output; bits 7:3 ignored
- i_usr_year_h … i_usr_seconds  in  8 each  programmed start time
- i_width_high_3..0  in  8 each  high width, big-endian bytes forming CNT_W bits
- i_width_period_3..0  in  8 each  period, same packing
- o_pulse  out  1  pulse output
- o_armed  out  1  waiting for start time
- o_running  out  1  pulse train active
- o_cfg_err  out  1  live period is zero

## Operation
- FSM states: IDLE, ARMED, RUN. Registered outputs; all outputs 0 after reset.
- IDLE: o_pulse = invert bit. enable=1 and period≠0 -> ARMED.
- ARMED: o_armed=1. Start event = (start-now bit) on any i_tick_us, or i_pps with all seven time fields equal to user fields. Start -> RUN, latch width/period into shadow registers, phase P=0.
- RUN: o_running=1. Each i_tick_us: P <= (P == period_s−1) ? 0 : P+1. On wrap to 0, reload shadows from live registers unless live period=0 (then keep old shadows).
- Raw pulse = (P < width_s); o_pulse = raw ^ invert. width_s=0 -> always inactive; width_s ≥ period_s -> always active.
- enable=0 in any state -> IDLE next cycle, P cleared, o_pulse to idle level.
- Live writes during RUN never affect the current period (shadowing).
- o_cfg_err = registered (live period == 0); ARMED is not entered while set; if it sets in ARMED, return to IDLE.
- Start time never matching (e.g. past time) -> stay ARMED indefinitely.

## Timing
- Start match evaluated on the i_pps cycle; o_running and the first active o_pulse appear the next cycle (P=0).
- Active duration = width_s ticks; period = period_s ticks, measured tick-to-tick.
- Disable latency: 1 cycle. Reset mid-RUN: outputs 0 next cycle, state IDLE.
- Simultaneous wrap and disable: disable wins.

## Configuration
- PULSE_GEN_PULSE_COUNT_EN defined: adds output o_pulse_count [15:0]. It increments on each period start (the start event and each wrap), wraps at 0xFFFF, and clears on reset or on entering IDLE.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Shared package (pulse_gen_pkg): FSM state enum; enable bit indices (EN_BIT=0, START_NOW_BIT=1, INVERT_BIT=2); CNT_W default.
- One sub-module, pulse_time_match: combinational 7-field comparison of current vs user time, qualified by i_pps, producing the start strobe.

## Test plan
- Enable=0x03, width=3, period=10, tick every 4 clk -> o_pulse high 3 ticks, low 7, repeating; o_running 1 cycle after first tick.
- User time 2024-05-01 12:00:05, enable=0x01, drive PPS through 12:00:04 -> 12:00:05 -> armed until the :05 pps; first pulse the following cycle.
- During RUN, write period 10 -> 20 mid-period -> current period stays 10 ticks; the next period is 20.
- width=0 -> o_pulse stays 0; width=15, period=10 -> o_pulse stays 1; enable bit2 set -> both inverted.
- Period=0 with enable=0x01 -> o_cfg_err=1, FSM stays IDLE; setting period=5 -> ARMED next cycle.
- Disable at P=2 in RUN, and separately assert i_rst -> o_pulse idle / 0 next cycle, state IDLE; with PULSE_GEN_PULSE_COUNT_EN, the count clears.
